// File: rtl/serpent_xts_pkg.sv
// Shared definitions for the XTS sequencing controllers around the serpent engine.
package serpent_xts_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TWK_REQ  = 3'd1,
    TWK_WAIT = 3'd2,
    IN_WAIT  = 3'd3,
    ENC_REQ  = 3'd4,
    ENC_WAIT = 3'd5,
    OUT      = 3'd6,
    DONE     = 3'd7
  } state_t;

  localparam logic [7:0] XTS_POLY      = 8'h87;
  localparam logic       KEY_SEL_DATA  = 1'b0;
  localparam logic       KEY_SEL_TWEAK = 1'b1;

endpackage

// File: rtl/xts_gf_mul_alpha.sv
// XTS tweak advance: multiply by alpha in GF(2^128), x^128 + x^7 + x^2 + x + 1.
module xts_gf_mul_alpha
  import serpent_xts_pkg::*;
(
  input  logic [127:0] tweak,
  output logic [127:0] tweak_next
);

  always_comb begin
    tweak_next = {tweak[126:0], 1'b0};
    if (tweak[127]) tweak_next[7:0] = tweak_next[7:0] ^ XTS_POLY;
  end

endmodule

// File: rtl/serpent_xts_ctrl.sv
// Steps one XTS sector through the shared iterative serpent engine:
// tweak generation under key2, then C = E_K1(P ^ T) ^ T per block.
module serpent_xts_ctrl
  import serpent_xts_pkg::*;
#(
  parameter int BLOCKS_PER_SECTOR = 32,
  parameter int CNT_W             = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [127:0]     i_sector,
  input  logic             i_key_ready,
  output logic             o_busy,
  input  logic             i_din_valid,
  input  logic [127:0]     i_din,
  output logic             o_din_ready,
  output logic             o_dout_valid,
  output logic [127:0]     o_dout,
  input  logic             i_dout_ready,
  output logic             o_eng_en,
  output logic             o_eng_key_sel,
  output logic [127:0]     o_eng_data,
  input  logic             i_eng_done,
  input  logic [127:0]     i_eng_data,
  output logic [CNT_W-1:0] o_blk_cnt,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(BLOCKS_PER_SECTOR - 1);

  state_t       state;
  logic [127:0] tweak;
  logic [127:0] tweak_next;

  xts_gf_mul_alpha u_mul_alpha (
    .tweak      (tweak),
    .tweak_next (tweak_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      tweak         <= '0;
      o_busy        <= 1'b0;
      o_din_ready   <= 1'b0;
      o_dout_valid  <= 1'b0;
      o_dout        <= '0;
      o_eng_en      <= 1'b0;
      o_eng_key_sel <= KEY_SEL_DATA;
      o_eng_data    <= '0;
      o_blk_cnt     <= '0;
      o_done        <= 1'b0;
    end else begin
      o_eng_en <= 1'b0;
      o_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start && i_key_ready) begin
            o_eng_data    <= i_sector;
            o_eng_key_sel <= KEY_SEL_TWEAK;
            o_busy        <= 1'b1;
            o_blk_cnt     <= '0;
            state         <= TWK_REQ;
          end
        end
        TWK_REQ: begin
          o_eng_en <= 1'b1;
          state    <= TWK_WAIT;
        end
        TWK_WAIT: begin
          if (i_eng_done) begin
            tweak         <= i_eng_data;
            o_eng_key_sel <= KEY_SEL_DATA;
            o_din_ready   <= 1'b1;
            state         <= IN_WAIT;
          end
        end
        IN_WAIT: begin
          // engine start is launched on the handshake edge itself to save a cycle
          if (i_din_valid) begin
            o_eng_data  <= i_din ^ tweak;
            o_din_ready <= 1'b0;
            o_eng_en    <= 1'b1;
            state       <= ENC_REQ;
          end
        end
        ENC_REQ: begin
          state <= ENC_WAIT;
        end
        ENC_WAIT: begin
          if (i_eng_done) begin
            o_dout       <= i_eng_data ^ tweak;
            o_dout_valid <= 1'b1;
            state        <= OUT;
          end
        end
        OUT: begin
          if (i_dout_ready) begin
            o_dout_valid <= 1'b0;
            tweak        <= tweak_next;
            if (o_blk_cnt == LAST_BLK) begin
              state <= DONE;
            end else begin
              o_blk_cnt   <= o_blk_cnt + CNT_W'(1);
              o_din_ready <= 1'b1;
              state       <= IN_WAIT;
            end
          end
        end
        DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serpent_xts_ctrl.md
Name: serpent_xts_ctrl

Overview:
Sequences one XTS sector through the shared iterative serpent encryption engine. Per sector it:
- generates the tweak by encrypting the sector number under key2;
- for each 128-bit block, computes C = E_K1(P ^ T) ^ T;
- advances T by GF(2^128) multiply-by-alpha.

It sits between the sector-level DMA/stream front end and the serpent_en instance. It owns the engine start strobe and the key-set select that steers the subkey memory.

Parameters:
BLOCKS_PER_SECTOR, 32, number of 128-bit blocks per sector (512 B); must be >= 1.
CNT_W, 6, width of the block counter; must hold BLOCKS_PER_SECTOR.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_start  in  1  start a sector; sampled only in IDLE
i_sector  in  128  sector number (tweak plaintext), captured on accepted start
i_key_ready  in  1  both subkey sets loaded; start is ignored while low
o_busy  out  1  high from accepted start until DONE completes
i_din_valid  in  1  plaintext block valid
i_din  in  128  plaintext block
o_din_ready  out  1  controller accepts plaintext (valid&ready = transfer)
o_dout_valid  out  1  ciphertext block valid
o_dout  out  128  ciphertext block
i_dout_ready  in  1  sink accepts ciphertext
o_eng_en  out  1  one-cycle start pulse to engine
o_eng_key_sel  out  1  0 = key1 (data), 1 = key2 (tweak); stable while engine runs
o_eng_data  out  128  engine plaintext, stable from o_eng_en until i_eng_done
i_eng_done  in  1  one-cycle pulse: engine result valid
i_eng_data  in  128  engine result
o_blk_cnt  out  CNT_W  index of the block currently in flight
o_done  out  1  one-cycle pulse after last ciphertext handshake

Behaviour:
- All outputs are registered. After reset every output is 0, the state is IDLE, and the tweak register is 0.
- Reset asserted in any state forces IDLE on the next edge; any in-flight engine result is then ignored.
- Tweak update: Tn = {T[126:0],1'b0} ^ (T[127] ? 128'h87 : 0). Little-endian integer convention: byte 0 = T[7:0].
- One block in flight at a time; there is no overlap of engine use between blocks.

State machine:
- IDLE: on i_start & i_key_ready:
  - capture i_sector into o_eng_data, set o_eng_key_sel=1, o_busy=1, o_blk_cnt=0;
  - go to TWK_REQ.
  - i_start while busy, or while i_key_ready=0, is ignored.
- TWK_REQ: o_eng_en=1 for exactly one cycle; go to TWK_WAIT.
- TWK_WAIT: on i_eng_done, T <= i_eng_data and o_eng_key_sel <= 0; go to IN_WAIT.
- IN_WAIT: o_din_ready=1. On i_din_valid:
  - o_eng_data <= i_din ^ T; o_din_ready drops next cycle;
  - go to ENC_REQ.
- ENC_REQ: o_eng_en pulse; go to ENC_WAIT.
- ENC_WAIT: on i_eng_done, o_dout <= i_eng_data ^ T and o_dout_valid <= 1; go to OUT.
- OUT: o_dout / o_dout_valid are held while i_dout_ready=0. On the handshake:
  - o_dout_valid <= 0 and T <= Tn;
  - if o_blk_cnt == BLOCKS_PER_SECTOR-1, go to DONE;
  - else o_blk_cnt += 1 and go to IN_WAIT.
- DONE: o_done=1 for one cycle and o_busy <= 0; return to IDLE.

Timing and boundary rules:
- Minimum latency: start -> o_eng_en is 2 edges; input handshake -> o_eng_en is 1 edge; i_eng_done -> o_dout_valid is 1 edge.
- i_eng_done outside TWK_WAIT / ENC_WAIT is ignored.
- A new i_start in the DONE cycle is ignored. It is accepted from IDLE on the next cycle.
- Tweak wrap: T[127]=1 feeds back 0x87; a shift out of the top bit is never lost.

Decomposition:
- Package serpent_xts_pkg holds:
  - state encoding localparams IDLE..DONE (3-bit);
  - XTS_POLY = 8'h87;
  - KEY_SEL_DATA = 1'b0 and KEY_SEL_TWEAK = 1'b1.
- One combinational sub-module, xts_gf_mul_alpha (128-bit in/out), implements Tn. It is reused by the decrypt-side controller.

Test Plan:
- Mock engine is identity (result = input, done 3 cycles after en). BLOCKS_PER_SECTOR=2, i_sector=128'h1, P0=P1=128'hA5A5..A5.
  - Tweak request: o_eng_key_sel=1 and o_eng_data=128'h1.
  - Block 0: o_eng_data=P0^1, o_dout=P0.
  - Block 1: o_eng_data=P1^2.
  - o_done pulses once; o_busy falls the same edge.
- i_sector=128'h8000_0000_0000_0000_0000_0000_0000_0000, identity engine -> block-1 engine input = P1 ^ 128'h87.
- i_dout_ready held low 10 cycles in OUT -> o_dout and o_dout_valid are stable. No o_eng_en, no o_din_ready, T unchanged until the handshake.
- i_start with i_key_ready=0 -> no o_busy. Second i_start during ENC_WAIT -> ignored; o_blk_cnt is unaffected.
- i_rst pulsed in ENC_WAIT, then a late i_eng_done -> outputs all 0, state IDLE, no o_dout_valid. A fresh start completes normally.
- BLOCKS_PER_SECTOR=32 with mock engine E(x)=~x -> 32 outputs, each equal to ~P, and o_blk_cnt sequence 0..31.
